// File: rtl/holes_draw_ctrl_pkg.sv
// Shared types and constants for the pool-table hole drawing slice.
package holes_pkg;

  localparam int unsigned NUM_HOLES_DEF = 6;
  localparam int unsigned HOLE_IDX_W    = 3;

  typedef enum logic {IDLE, HIGHLIGHT} hole_state_t;

  typedef logic [7:0] rgb_t;

endpackage

// File: rtl/hole_priority_enc.sv
// Combinational lowest-index priority encoder over a request vector.
module hole_priority_enc
  import holes_pkg::*;
#(
  parameter int unsigned N = NUM_HOLES_DEF
) (
  input  logic [N-1:0]          req,
  output logic [HOLE_IDX_W-1:0] idx,
  output logic                  valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = |req;
    for (int unsigned i = N; i > 0; i--) begin
      if (req[i-1]) idx = HOLE_IDX_W'(i - 1);
    end
  end

endmodule

// File: rtl/holes_draw_ctrl.sv
// Six-hole drawing controller: registered priority pixel merge plus
// pocket-event latching with a timed, blinking highlight of the hole.
module holes_draw_ctrl
  import holes_pkg::*;
#(
  parameter int unsigned NUM_HOLES        = NUM_HOLES_DEF,
  parameter int unsigned HIGHLIGHT_FRAMES = 60,
  parameter int unsigned BLINK_PERIOD     = 8,
  parameter rgb_t        HIGHLIGHT_COLOR  = 8'hFC
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   startOfFrame,
  input  logic [8*NUM_HOLES-1:0] holes_VGA,
  input  logic [NUM_HOLES-1:0]   holes_DrawingRequest,
  input  logic [NUM_HOLES-1:0]   pocket_event,
  output logic                   drawingRequest,
  output logic [7:0]             RGBout,
  output logic [HOLE_IDX_W-1:0]  pocketed_hole,
  output logic                   pocket_valid,
  output logic                   highlight_active
);

  localparam int unsigned FC_W = (HIGHLIGHT_FRAMES > 1) ? $clog2(HIGHLIGHT_FRAMES) : 1;
  localparam int unsigned BC_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(HIGHLIGHT_FRAMES - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_PERIOD - 1);

  hole_state_t           state, state_next;
  logic [FC_W-1:0]       frame_cnt, frame_cnt_next;
  logic [BC_W-1:0]       blink_cnt, blink_cnt_next;
  logic                  blink_on, blink_on_next;
  logic [HOLE_IDX_W-1:0] pocketed_hole_next;
  logic                  pocket_valid_next;

  logic                  drawreq_next;
  rgb_t                  rgb_next;

  logic [HOLE_IDX_W-1:0] pix_idx, ev_idx;
  logic                  pix_valid, ev_valid;

  rgb_t                  vga_arr [NUM_HOLES];

  for (genvar g = 0; g < NUM_HOLES; g++) begin : g_vga
    assign vga_arr[g] = holes_VGA[8*g +: 8];
  end

  hole_priority_enc #(.N(NUM_HOLES)) u_pix_enc (
    .req   (holes_DrawingRequest),
    .idx   (pix_idx),
    .valid (pix_valid)
  );

  hole_priority_enc #(.N(NUM_HOLES)) u_ev_enc (
    .req   (pocket_event),
    .idx   (ev_idx),
    .valid (ev_valid)
  );

  // State register: FSM state, highlight counters and pocket report.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      frame_cnt     <= '0;
      blink_cnt     <= '0;
      blink_on      <= 1'b0;
      pocketed_hole <= '0;
      pocket_valid  <= 1'b0;
    end else begin
      state         <= state_next;
      frame_cnt     <= frame_cnt_next;
      blink_cnt     <= blink_cnt_next;
      blink_on      <= blink_on_next;
      pocketed_hole <= pocketed_hole_next;
      pocket_valid  <= pocket_valid_next;
    end
  end

  // Next-state logic: a pocket event always (re)starts the highlight and
  // beats a coincident startOfFrame, including the final-frame one.
  always_comb begin
    state_next         = state;
    frame_cnt_next     = frame_cnt;
    blink_cnt_next     = blink_cnt;
    blink_on_next      = blink_on;
    pocketed_hole_next = pocketed_hole;
    pocket_valid_next  = 1'b0;
    if (ev_valid) begin
      state_next         = HIGHLIGHT;
      frame_cnt_next     = '0;
      blink_cnt_next     = '0;
      blink_on_next      = 1'b1;
      pocketed_hole_next = ev_idx;
      pocket_valid_next  = 1'b1;
    end else begin
      case (state)
        IDLE: ;
        HIGHLIGHT: begin
          if (startOfFrame) begin
            if (frame_cnt == FC_LAST) begin
              state_next     = IDLE;
              frame_cnt_next = '0;
              blink_cnt_next = '0;
              blink_on_next  = 1'b0;
            end else begin
              frame_cnt_next = frame_cnt + 1'b1;
              if (blink_cnt == BC_LAST) begin
                blink_cnt_next = '0;
                blink_on_next  = ~blink_on;
              end else begin
                blink_cnt_next = blink_cnt + 1'b1;
              end
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output logic: pixel winner colour (with highlight override) and status.
  always_comb begin
    highlight_active = (state == HIGHLIGHT);
    drawreq_next     = pix_valid;
    rgb_next         = '0;
    if (pix_valid) begin
      if (state == HIGHLIGHT && blink_on && pix_idx == pocketed_hole)
        rgb_next = HIGHLIGHT_COLOR;
      else
        rgb_next = vga_arr[pix_idx];
    end
  end

  // Pixel pipeline register: one clock of latency to the objects mux.
  always_ff @(posedge clk) begin
    if (reset) begin
      drawingRequest <= 1'b0;
      RGBout         <= '0;
    end else begin
      drawingRequest <= drawreq_next;
      RGBout         <= rgb_next;
    end
  end

endmodule

// File: tb/tb_holes_draw_ctrl.sv
// Scenario bench for holes_draw_ctrl: expected pixels are queued as stimulus
// is driven and popped when the registered output appears.
module tb_holes_draw_ctrl;
  import holes_pkg::*;

  localparam int unsigned NH = 6;
  localparam int unsigned HF = 60;
  localparam int unsigned BP = 8;

  localparam logic [7:0] C0 = 8'h11, C1 = 8'h22, C2 = 8'h1C;
  localparam logic [7:0] C3 = 8'hE0, C4 = 8'h55, C5 = 8'hA5;
  localparam logic [7:0] HC = 8'hFC;
  localparam logic [8*NH-1:0] VGA_DEF = {C5, C4, C3, C2, C1, C0};

  typedef struct packed {
    logic       dr;
    logic [7:0] rgb;
  } pix_t;

  localparam logic [NH-1:0] PIX_REQ [6] = '{6'b001100, 6'b000000, 6'b100000,
                                            6'b111111, 6'b110000, 6'b001010};
  localparam pix_t PIX_EXP [6] = '{'{1'b1, C2}, '{1'b0, 8'h00}, '{1'b1, C5},
                                   '{1'b1, C0}, '{1'b1, C4}, '{1'b1, C1}};

  logic              clk = 1'b0;
  logic              reset;
  logic              startOfFrame;
  logic [8*NH-1:0]   holes_VGA;
  logic [NH-1:0]     holes_DrawingRequest;
  logic [NH-1:0]     pocket_event;
  logic              drawingRequest;
  logic [7:0]        RGBout;
  logic [2:0]        pocketed_hole;
  logic              pocket_valid;
  logic              highlight_active;

  pix_t pix_q [$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  holes_draw_ctrl #(
    .NUM_HOLES        (NH),
    .HIGHLIGHT_FRAMES (HF),
    .BLINK_PERIOD     (BP),
    .HIGHLIGHT_COLOR  (HC)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .startOfFrame         (startOfFrame),
    .holes_VGA            (holes_VGA),
    .holes_DrawingRequest (holes_DrawingRequest),
    .pocket_event         (pocket_event),
    .drawingRequest       (drawingRequest),
    .RGBout               (RGBout),
    .pocketed_hole        (pocketed_hole),
    .pocket_valid         (pocket_valid),
    .highlight_active     (highlight_active)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One frame pulse followed by one quiet cycle; outputs not inspected.
  task automatic pulse_sof;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
  endtask

  // Pixel expected for hole 4 after k frame pulses of its highlight.
  function automatic pix_t exp_h4(input int k);
    pix_t r;
    if (k >= int'(HF))            r = '{1'b1, C4};
    else if (((k / BP) % 2) == 0) r = '{1'b1, HC};
    else                          r = '{1'b1, C4};
    return r;
  endfunction

  function automatic pix_t ref_pix(input logic [NH-1:0] r, input logic [8*NH-1:0] v);
    pix_t res;
    res = '{1'b0, 8'h00};
    for (int j = NH - 1; j >= 0; j--) begin
      if (r[j]) res = '{1'b1, v[8*j +: 8]};
    end
    return res;
  endfunction

  task automatic test_reset;
    pix_t p;
    reset = 1'b1; startOfFrame = 1'b0; pocket_event = '0;
    holes_DrawingRequest = '0; holes_VGA = VGA_DEF;
    repeat (2) tick();
    holes_DrawingRequest = '1;
    pix_q.push_back('{1'b0, 8'h00});
    tick();
    p = pix_q.pop_front(); tests++;
    if ({drawingRequest, RGBout} !== p) begin
      fails++; $display("FAIL reset_pix got dr=%0b rgb=%h exp dr=%0b rgb=%h", drawingRequest, RGBout, p.dr, p.rgb);
    end
    tests++;
    if (pocketed_hole !== 3'd0) begin fails++; $display("FAIL reset_hole got %0d exp 0", pocketed_hole); end
    tests++;
    if (pocket_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b exp 0", pocket_valid); end
    tests++;
    if (highlight_active !== 1'b0) begin fails++; $display("FAIL reset_hl got %0b exp 0", highlight_active); end
    reset = 1'b0;
    holes_DrawingRequest = '0;
    tick();
  endtask

  task automatic test_pixel;
    pix_t p;
    for (int i = 0; i < 6; i++) begin
      holes_DrawingRequest = PIX_REQ[i];
      pix_q.push_back(PIX_EXP[i]);
      tick();
      p = pix_q.pop_front(); tests++;
      if ({drawingRequest, RGBout} !== p) begin
        fails++; $display("FAIL pixel[%0d] got dr=%0b rgb=%h exp dr=%0b rgb=%h", i, drawingRequest, RGBout, p.dr, p.rgb);
      end
    end
    holes_DrawingRequest = '0;
  endtask

  task automatic test_pocket;
    pix_t p;
    pocket_event = 6'b010000;
    pix_q.push_back('{1'b0, 8'h00});
    tick();
    pocket_event = '0;
    p = pix_q.pop_front(); tests++;
    if ({drawingRequest, RGBout} !== p) begin
      fails++; $display("FAIL pocket_pix got dr=%0b rgb=%h exp dr=%0b rgb=%h", drawingRequest, RGBout, p.dr, p.rgb);
    end
    tests++;
    if (pocket_valid !== 1'b1) begin fails++; $display("FAIL pocket_valid got %0b exp 1", pocket_valid); end
    tests++;
    if (pocketed_hole !== 3'd4) begin fails++; $display("FAIL pocket_hole got %0d exp 4", pocketed_hole); end
    tests++;
    if (highlight_active !== 1'b1) begin fails++; $display("FAIL pocket_hl got %0b exp 1", highlight_active); end
    tick();
    tests++;
    if (pocket_valid !== 1'b0) begin fails++; $display("FAIL pocket_valid_once got %0b exp 0", pocket_valid); end
    tests++;
    if (pocketed_hole !== 3'd4) begin fails++; $display("FAIL pocket_hold got %0d exp 4", pocketed_hole); end
  endtask

  task automatic test_blink_timeout;
    pix_t p;
    holes_DrawingRequest = 6'b010000;
    pix_q.push_back(exp_h4(0));
    tick();
    p = pix_q.pop_front(); tests++;
    if ({drawingRequest, RGBout} !== p) begin
      fails++; $display("FAIL blink_k0 got rgb=%h exp rgb=%h", RGBout, p.rgb);
    end
    for (int k = 1; k <= int'(HF); k++) begin
      startOfFrame = 1'b1;
      pix_q.push_back(exp_h4(k - 1));
      tick();
      p = pix_q.pop_front(); tests++;
      if ({drawingRequest, RGBout} !== p) begin
        fails++; $display("FAIL blink_sof k=%0d got rgb=%h exp rgb=%h", k, RGBout, p.rgb);
      end
      startOfFrame = 1'b0;
      pix_q.push_back(exp_h4(k));
      tick();
      p = pix_q.pop_front(); tests++;
      if ({drawingRequest, RGBout} !== p) begin
        fails++; $display("FAIL blink_after k=%0d got rgb=%h exp rgb=%h", k, RGBout, p.rgb);
      end
      tests++;
      if (highlight_active !== (k < int'(HF))) begin
        fails++; $display("FAIL hl_span k=%0d got %0b exp %0b", k, highlight_active, (k < int'(HF)));
      end
    end
    tests++;
    if (pocketed_hole !== 3'd4) begin fails++; $display("FAIL hold_after_timeout got %0d exp 4", pocketed_hole); end
    holes_DrawingRequest = '0;
  endtask

  task automatic test_simultaneous;
    pix_t p;
    pocket_event = 6'b100010;
    pix_q.push_back('{1'b0, 8'h00});
    tick();
    pocket_event = '0;
    p = pix_q.pop_front(); tests++;
    if ({drawingRequest, RGBout} !== p) begin
      fails++; $display("FAIL simul_pix got dr=%0b rgb=%h exp dr=%0b rgb=%h", drawingRequest, RGBout, p.dr, p.rgb);
    end
    tests++;
    if (pocketed_hole !== 3'd1) begin fails++; $display("FAIL simul_hole got %0d exp 1", pocketed_hole); end
    tests++;
    if (pocket_valid !== 1'b1) begin fails++; $display("FAIL simul_valid got %0b exp 1", pocket_valid); end
    holes_DrawingRequest = 6'b100000;
    pix_q.push_back('{1'b1, C5});
    tick();
    p = pix_q.pop_front(); tests++;
    if ({drawingRequest, RGBout} !== p) begin
      fails++; $display("FAIL simul_h5_raw got rgb=%h exp rgb=%h", RGBout, p.rgb);
    end
    tests++;
    if (pocket_valid !== 1'b0) begin fails++; $display("FAIL simul_single_pulse got %0b exp 0", pocket_valid); end
    holes_DrawingRequest = 6'b100010;
    pix_q.push_back('{1'b1, HC});
    tick();
    p = pix_q.pop_front(); tests++;
    if ({drawingRequest, RGBout} !== p) begin
      fails++; $display("FAIL simul_h1_hl got rgb=%h exp rgb=%h", RGBout, p.rgb);
    end
    holes_DrawingRequest = '0;
  endtask

  task automatic test_restart_on_final;
    pix_t p;
    holes_DrawingRequest = '0;
    repeat (HF - 1) pulse_sof();
    startOfFrame = 1'b1;
    pocket_event = 6'b001000;
    tick();
    startOfFrame = 1'b0;
    pocket_event = '0;
    tests++;
    if (pocketed_hole !== 3'd3) begin fails++; $display("FAIL restart_hole got %0d exp 3", pocketed_hole); end
    tests++;
    if (pocket_valid !== 1'b1) begin fails++; $display("FAIL restart_valid got %0b exp 1", pocket_valid); end
    tests++;
    if (highlight_active !== 1'b1) begin fails++; $display("FAIL restart_hl got %0b exp 1", highlight_active); end
    holes_DrawingRequest = 6'b001000;
    pulse_sof();
    tests++;
    if (highlight_active !== 1'b1) begin fails++; $display("FAIL restart_hl_kept got %0b exp 1", highlight_active); end
    pix_q.push_back('{1'b1, HC});
    tick();
    p = pix_q.pop_front(); tests++;
    if ({drawingRequest, RGBout} !== p) begin
      fails++; $display("FAIL restart_f1 got rgb=%h exp rgb=%h", RGBout, p.rgb);
    end
    repeat (BP - 2) pulse_sof();
    pix_q.push_back('{1'b1, HC});
    tick();
    p = pix_q.pop_front(); tests++;
    if ({drawingRequest, RGBout} !== p) begin
      fails++; $display("FAIL restart_f7 got rgb=%h exp rgb=%h", RGBout, p.rgb);
    end
    pulse_sof();
    pix_q.push_back('{1'b1, C3});
    tick();
    p = pix_q.pop_front(); tests++;
    if ({drawingRequest, RGBout} !== p) begin
      fails++; $display("FAIL restart_f8 got rgb=%h exp rgb=%h", RGBout, p.rgb);
    end
  endtask

  task automatic test_reset_mid;
    pix_t p;
    pocket_event = 6'b001000;
    tick();
    pocket_event = '0;
    holes_DrawingRequest = 6'b001000;
    reset = 1'b1;
    pix_q.push_back('{1'b0, 8'h00});
    tick();
    p = pix_q.pop_front(); tests++;
    if ({drawingRequest, RGBout} !== p) begin
      fails++; $display("FAIL rstmid_pix got dr=%0b rgb=%h exp dr=0 rgb=00", drawingRequest, RGBout);
    end
    tests++;
    if ({pocketed_hole, pocket_valid, highlight_active} !== 5'b0) begin
      fails++; $display("FAIL rstmid_status got hole=%0d pv=%0b hl=%0b exp all 0", pocketed_hole, pocket_valid, highlight_active);
    end
    reset = 1'b0;
    pix_q.push_back('{1'b1, C3});
    tick();
    p = pix_q.pop_front(); tests++;
    if ({drawingRequest, RGBout} !== p) begin
      fails++; $display("FAIL rstmid_raw got dr=%0b rgb=%h exp dr=1 rgb=%h", drawingRequest, RGBout, p.rgb);
    end
    tests++;
    if (highlight_active !== 1'b0) begin fails++; $display("FAIL rstmid_hl got %0b exp 0", highlight_active); end
    holes_DrawingRequest = '0;
  endtask

  task automatic test_back_to_back;
    pix_t p;
    for (int i = 0; i < 24; i++) begin
      holes_DrawingRequest = NH'($urandom_range(0, 63));
      holes_VGA = {$urandom, $urandom};
      pix_q.push_back(ref_pix(holes_DrawingRequest, holes_VGA));
      tick();
      p = pix_q.pop_front(); tests++;
      if ({drawingRequest, RGBout} !== p) begin
        fails++; $display("FAIL b2b[%0d] got dr=%0b rgb=%h exp dr=%0b rgb=%h", i, drawingRequest, RGBout, p.dr, p.rgb);
      end
    end
    holes_DrawingRequest = '0;
    holes_VGA = VGA_DEF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pixel();
    test_pocket();
    test_blink_timeout();
    test_simultaneous();
    test_restart_on_final();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
